nand3_sweep_ctrl: RTL and testbench
===================================

# nand3_sweep_ctrl

Sequencing controller that exhaustively exercises an external three-input NAND gate in the VLSI lab flow. On a start request it drives all eight input vectors to the gate, waits a programmable settle time, samples the gate output, and compares it against the golden NAND value. It reports pass/fail, a mismatch count and the first failing vector. It sits between the bench/top-level control logic and the gate instance, and is synthesised alongside it in Design Vision.

## Interface
- SETTLE, default 2: wait cycles between applying a vector and sampling `y`; legal range 0..15.
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle sweep request; accepted only in IDLE.
- a, b, c  out  1 each  registered gate inputs; {a,b,c} = current vector, a = MSB.
- y  in  1  gate output under test.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  result of last sweep; 1 iff err_count == 0; held until next accepted start.
- err_count  out  4  mismatches in last sweep, 0..8.
- fail_vec  out  3  first mismatching vector; valid only when fail_valid = 1.
- fail_valid  out  1  at least one mismatch recorded in last sweep.

## Operation
- State machine: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE: if start = 1, go to APPLY, clear err_count/fail_valid/fail_vec/pass, set vector = 3'b000.
- APPLY (1 cycle): vector is on a/b/c. Load settle counter with SETTLE-1. Next state is SETTLE, or CHECK if SETTLE = 0.
- SETTLE: decrement counter; at 0 go to CHECK.
- CHECK (1 cycle): compare y with expected = ~(a & b & c).
  - On mismatch, increment err_count.
  - On the first mismatch, capture fail_vec = vector and set fail_valid.
  - If vector == 3'b111, go to DONE; else increment vector and go to APPLY.
- DONE (1 cycle):
  - done = 1.
  - pass = (err_count == 0), using the updated count including the final CHECK.
  - Go to IDLE.
- start outside IDLE: ignored, no queuing.
- a/b/c hold their last vector in IDLE after a sweep; they return to 000 only on reset or a new start.
- Vector counter is 3 bits. Increments only in CHECK and never wraps inside a sweep; the terminal test on 3'b111 precedes the increment.
- err_count never exceeds 8, so no saturation logic is needed.

## Timing
- Reset values: a = b = c = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_vec = 000, fail_valid = 0, state = IDLE.
- Start accepted at edge k: state = APPLY and busy = 1 after edge k.
- Cycles per vector: SETTLE + 2.
- done is high for exactly one cycle, 8·(SETTLE+2) cycles after edge k. For SETTLE = 2, done is high in cycle k+33 (counting the cycle after edge k as k+1).
- busy falls with the same edge that deasserts done.
- Results (pass, err_count, fail_vec, fail_valid) are stable from the done cycle until the next accepted start.
- y is sampled on the rising edge that ends CHECK.
- rst mid-sweep: next edge forces all reset values. No done pulse is produced and partial results are discarded.
- start and rst asserted together: rst wins.

## Structure
- Shared package holds:
  - state encoding constants (IDLE, APPLY, SETTLE, CHECK, DONE; 3-bit);
  - NUM_VEC = 8;
  - LAST_VEC = 3'b111;
  - counter width constant for SETTLE (4 bits).
- Single flat module; no sub-module. The gate under test stays external and is wired to a/b/c/y at top level. The golden NAND is one expression inside CHECK.

## Test plan
- Good gate, SETTLE = 2: single start → done in cycle k+33, pass = 1, err_count = 0, fail_valid = 0, all 8 vectors seen on a/b/c in order 000..111.
- y stuck at 1 → only vector 111 mismatches: err_count = 1, fail_vec = 3'b111, fail_valid = 1, pass = 0.
- y stuck at 0 → vectors 000..110 mismatch: err_count = 7, fail_vec = 3'b000, pass = 0.
- SETTLE = 0: good gate → done 16 cycles after start edge. Start re-pulsed while busy → ignored; only one done.
- rst asserted at cycle k+10 → all outputs at reset values next cycle, no done. A new start afterwards completes normally with pass = 1.
- Back-to-back sweeps (faulty then good): second start clears results, final pass = 1, err_count = 0.

Source files
------------

// File: rtl/nand3_sweep_ctrl_pkg.sv
// rtl/nand3_sweep_ctrl_pkg.sv - shared constants and state encoding for the NAND3 sweep controller
package nand3_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int            NUM_VEC  = 8;
    localparam logic [2:0]    LAST_VEC = 3'b111;
    localparam int            SETTLE_W = 4;
    localparam int            ERR_W    = $clog2(NUM_VEC + 1);

endpackage

// File: rtl/nand3_sweep_ctrl.sv
// rtl/nand3_sweep_ctrl.sv - drives all eight vectors into an external NAND3 and checks its output
module nand3_sweep_ctrl
    import nand3_sweep_ctrl_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       fail_vec,
    output logic             fail_valid
);

    // SETTLE = 0 skips the settle state entirely, so the load value is irrelevant there.
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
        (SETTLE == 0) ? '0 : SETTLE_W'(SETTLE - 1);

    state_t              state_q, state_d;
    logic [2:0]          vec_q, vec_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [2:0]          fvec_q, fvec_d;
    logic                fvalid_q, fvalid_d;
    logic                pass_q, pass_d;
    logic                mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fvalid_q <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fvalid_q <= fvalid_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fvalid_d = fvalid_q;
        pass_d   = pass_q;
        mismatch = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_APPLY;
                    vec_d    = '0;
                    err_d    = '0;
                    fvec_d   = '0;
                    fvalid_d = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            ST_APPLY: begin
                cnt_d   = SETTLE_LOAD;
                state_d = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                mismatch = (y != ~(vec_q[2] & vec_q[1] & vec_q[0]));
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!fvalid_q) begin
                        fvec_d   = vec_q;
                        fvalid_d = 1'b1;
                    end
                end
                // Verdict is taken from the count that already includes this last check.
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign a          = vec_q[2];
    assign b          = vec_q[1];
    assign c          = vec_q[0];
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_vec   = fvec_q;
    assign fail_valid = fvalid_q;

endmodule

// File: tb/tb_nand3_sweep_ctrl.sv
// tb/tb_nand3_sweep_ctrl.sv - directed self-checking bench for nand3_sweep_ctrl
module tb_nand3_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [1:0] mode = 2'd0;

    logic       a0, b0, c0, y0, busy0, done0, pass0, fvalid0;
    logic [3:0] err0;
    logic [2:0] fvec0;
    logic       a1, b1, c1, y1, busy1, done1, pass1, fvalid1;
    logic [3:0] err1;
    logic [2:0] fvec1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // mode 0: good gate, 1: stuck at 1, 2: stuck at 0
    assign y0 = (mode == 2'd0) ? ~(a0 & b0 & c0) : (mode == 2'd1);
    assign y1 = ~(a1 & b1 & c1);

    nand3_sweep_ctrl #(.SETTLE(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .a(a0), .b(b0), .c(c0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fvec0), .fail_valid(fvalid0)
    );

    nand3_sweep_ctrl #(.SETTLE(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .c(c1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fvec1), .fail_valid(fvalid1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start dut0, watch 45 cycles; lat = cycle index of first done (cycle after start edge = 1).
    task automatic run_sweep(output int lat, output int ndone, output int last_vec, output bit order_ok);
        logic [2:0] cur;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        lat = -1; ndone = 0; order_ok = 1'b1; cur = 3'd0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (busy0 && ({a0, b0, c0} != cur)) begin
                if ({a0, b0, c0} != cur + 3'd1) order_ok = 1'b0;
                cur = {a0, b0, c0};
            end
            if (done0) begin
                ndone++;
                if (lat < 0) lat = cyc;
            end
            tick();
        end
        last_vec = int'(cur);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({a0, b0, c0, busy0, done0, pass0, err0, fvec0, fvalid0} !== 15'd0) begin
            errors++;
            $display("FAIL reset_values actual=%b required=0", {a0, b0, c0, busy0, done0, pass0, err0, fvec0, fvalid0});
        end
        rst = 1'b1; start0 = 1'b1;
        tick();
        rst = 1'b0; start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_beats_start busy actual=%b required=0", busy0);
        end
    endtask

    task automatic test_good_sweep();
        int lat, nd, lv;
        bit ok;
        mode = 2'd0;
        run_sweep(lat, nd, lv, ok);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL good_latency actual=%0d required=33", lat); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL good_done_count actual=%0d required=1", nd); end
        checks++;
        if (!ok || lv !== 7) begin errors++; $display("FAIL good_vec_order ok=%0d last=%0d required ok=1 last=7", ok, lv); end
        checks++;
        if ({pass0, err0, fvalid0} !== 6'b1_0000_0) begin
            errors++;
            $display("FAIL good_results pass=%b err=%0d fvalid=%b required pass=1 err=0 fvalid=0", pass0, err0, fvalid0);
        end
        checks++;
        if ({a0, b0, c0, busy0} !== 4'b1110) begin
            errors++;
            $display("FAIL good_idle_hold abc_busy=%b required=1110", {a0, b0, c0, busy0});
        end
    endtask

    task automatic test_stuck1();
        int lat, nd, lv;
        bit ok;
        mode = 2'd1;
        run_sweep(lat, nd, lv, ok);
        checks++;
        if ({pass0, err0, fvalid0, fvec0} !== {1'b0, 4'd1, 1'b1, 3'b111}) begin
            errors++;
            $display("FAIL stuck1_results pass=%b err=%0d fvalid=%b fvec=%b required 0/1/1/111", pass0, err0, fvalid0, fvec0);
        end
    endtask

    task automatic test_stuck0();
        int lat, nd, lv;
        bit ok;
        mode = 2'd2;
        run_sweep(lat, nd, lv, ok);
        checks++;
        if ({pass0, err0, fvalid0, fvec0} !== {1'b0, 4'd7, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL stuck0_results pass=%b err=%0d fvalid=%b fvec=%b required 0/7/1/000", pass0, err0, fvalid0, fvec0);
        end
    endtask

    task automatic test_settle0();
        int lat, nd;
        lat = -1; nd = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            start1 = (cyc == 5 || cyc == 12);
            if (done1) begin
                nd++;
                if (lat < 0) lat = cyc;
            end
            tick();
        end
        start1 = 1'b0;
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL settle0_latency actual=%0d required=17", lat); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL settle0_done_count actual=%0d required=1", nd); end
        checks++;
        if ({pass1, err1, fvalid1} !== 6'b1_0000_0) begin
            errors++;
            $display("FAIL settle0_results pass=%b err=%0d fvalid=%b required 1/0/0", pass1, err1, fvalid1);
        end
    endtask

    task automatic test_rst_mid();
        int nd, lat, lv;
        bit ok;
        mode = 2'd2;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({a0, b0, c0, busy0, done0, pass0, err0, fvec0, fvalid0} !== 15'd0) begin
            errors++;
            $display("FAIL rst_mid_values actual=%b required=0", {a0, b0, c0, busy0, done0, pass0, err0, fvec0, fvalid0});
        end
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done0 || busy0) nd++;
            tick();
        end
        checks++;
        if (nd !== 0) begin errors++; $display("FAIL rst_mid_no_done actual=%0d required=0", nd); end
        mode = 2'd0;
        run_sweep(lat, nd, lv, ok);
        checks++;
        if ({pass0, err0, lat} !== {1'b1, 4'd0, 33}) begin
            errors++;
            $display("FAIL rst_mid_resweep pass=%b err=%0d lat=%0d required 1/0/33", pass0, err0, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nd, lv;
        bit ok;
        mode = 2'd1;
        run_sweep(lat, nd, lv, ok);
        mode = 2'd0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        checks++;
        if ({busy0, pass0, err0, fvalid0, fvec0} !== {1'b1, 1'b0, 4'd0, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL b2b_clear busy=%b pass=%b err=%0d fvalid=%b fvec=%b required 1/0/0/0/000", busy0, pass0, err0, fvalid0, fvec0);
        end
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if ({pass0, err0, fvalid0} !== 6'b1_0000_0) begin
            errors++;
            $display("FAIL b2b_final pass=%b err=%0d fvalid=%b required 1/0/0", pass0, err0, fvalid0);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_good_sweep();
        test_stuck1();
        test_stuck0();
        test_settle0();
        test_rst_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
